// File: rtl/spi_flash_master.sv
// -----------------------------------------------------------------------------
// spi_flash_master
//
// Minimal SPI (mode 0) master for serial NOR flash. It supports four commands:
// 03 read, 02 program, 06 write-enable and 04 write-disable. A transaction
// walks SEL -> SHIFT (-> GAP -> SHIFT)* -> DESEL -> FIN. Any other command is
// rejected: err_o and done_o pulse together with no SPI activity.
//
// Parameters
//   CLK_DIV  SCK half-period in clk_i cycles (>= 1)
//   GAP      idle clk_i cycles, SCK low, between bytes of one transaction (>= 1)
//   SS_HIGH  clk_i cycles ss_o is held high after a transaction (>= 1)
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           request strobe, honoured only while busy_o = 0
//   cmd_i/adr_i/len_i command, 24-bit address, data byte count minus one
//   wdat_i            program data byte, sampled while wdat_req_o = 1
//   wdat_req_o        pulse: wdat_i consumed this cycle
//   rdat_o/rdat_vld_o last read byte / one-cycle update strobe
//   busy_o/done_o     transaction in progress / one-cycle completion pulse
//   err_o             one-cycle pulse: unsupported command
//   sck_o/ss_o        SPI clock (idles low) / active-low slave select
//   mosi_o/miso_i     SPI data out / in
// -----------------------------------------------------------------------------
module spi_flash_master #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8,
    parameter int SS_HIGH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  cmd_i,
    input  logic [23:0] adr_i,
    input  logic [7:0]  len_i,
    input  logic [7:0]  wdat_i,
    output logic        wdat_req_o,
    output logic [7:0]  rdat_o,
    output logic        rdat_vld_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        sck_o,
    output logic        ss_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_GAP,
        ST_DESEL,
        ST_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;           // cycles spent in current state / half-period
    logic               phase_q, phase_d;       // 0: SCK low half, 1: SCK high half
    logic [2:0]         bit_q, bit_d;           // bit index within current byte
    logic [7:0]         tx_q, tx_d;             // outgoing byte, MSB on mosi_o
    logic [6:0]         rx_q, rx_d;             // first seven bits of incoming byte
    logic [23:0]        adr_q, adr_d;
    logic [1:0]         hdr_q, hdr_d;           // address bytes still to send
    logic [8:0]         data_cnt_q, data_cnt_d; // data bytes still to load (len+1 max 256)
    logic               has_data_q, has_data_d;
    logic               wr_q, wr_d;
    logic               cur_data_q, cur_data_d; // byte being shifted is a data byte
    logic               err_q, err_d;
    logic [7:0]         rdat_q, rdat_d;
    logic               rdat_vld_q, rdat_vld_d;

    // Command decode of the incoming request.
    logic cmd_ok, cmd_has_data, cmd_wr;

    always_comb begin
        cmd_ok       = 1'b1;
        cmd_has_data = 1'b0;
        cmd_wr       = 1'b0;
        case (cmd_i)
            8'h03:        cmd_has_data = 1'b1;
            8'h02: begin
                cmd_has_data = 1'b1;
                cmd_wr       = 1'b1;
            end
            8'h06, 8'h04: ;
            default:      cmd_ok = 1'b0;
        endcase
    end

    // FIN has busy_o low, so a request arriving there is honoured too.
    logic accept, half_done, sel_done, byte_done, gap_done, desel_done, more_bytes;

    assign accept     = start_i && (state_q == ST_IDLE || state_q == ST_FIN);
    assign half_done  = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign sel_done   = (state_q == ST_SEL) && half_done;
    assign byte_done  = (state_q == ST_SHIFT) && half_done && phase_q && (bit_q == 3'd7);
    assign gap_done   = (state_q == ST_GAP) && (cnt_q == CNT_W'(GAP - 1));
    assign desel_done = (state_q == ST_DESEL) && (cnt_q == CNT_W'(SS_HIGH - 1));
    assign more_bytes = (hdr_q != 2'd0) || (has_data_q && data_cnt_q != 9'd0);

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_FIN: begin
                if (accept) state_d = cmd_ok ? ST_SEL : ST_FIN;
                else        state_d = ST_IDLE;
            end
            ST_SEL:   if (sel_done)   state_d = ST_SHIFT;
            ST_SHIFT: if (byte_done)  state_d = more_bytes ? ST_GAP : ST_DESEL;
            ST_GAP:   if (gap_done)   state_d = ST_SHIFT;
            ST_DESEL: if (desel_done) state_d = ST_FIN;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        ss_o       = !(state_q == ST_SEL || state_q == ST_SHIFT || state_q == ST_GAP);
        sck_o      = (state_q == ST_SHIFT) && phase_q;
        mosi_o     = (state_q == ST_SHIFT) && tx_q[7];
        busy_o     = (state_q == ST_SEL) || (state_q == ST_SHIFT) ||
                     (state_q == ST_GAP) || (state_q == ST_DESEL);
        done_o     = (state_q == ST_FIN);
        err_o      = (state_q == ST_FIN) && err_q;
        // Last GAP cycle ahead of a program data byte.
        wdat_req_o = gap_done && (hdr_q == 2'd0) && wr_q;
        rdat_o     = rdat_q;
        rdat_vld_o = rdat_vld_q;
    end

    // ---------------------------------------------------------------- datapath next values
    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        phase_d    = phase_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        adr_d      = adr_q;
        hdr_d      = hdr_q;
        data_cnt_d = data_cnt_q;
        has_data_d = has_data_q;
        wr_d       = wr_q;
        cur_data_d = cur_data_q;
        err_d      = err_q;
        rdat_d     = rdat_q;
        rdat_vld_d = 1'b0;

        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_FIN) begin
            cnt_d = '0;
        end

        if (accept) begin
            tx_d       = cmd_i;
            adr_d      = adr_i;
            hdr_d      = cmd_has_data ? 2'd3 : 2'd0;
            data_cnt_d = {1'b0, len_i} + 9'd1;
            has_data_d = cmd_has_data;
            wr_d       = cmd_wr;
            cur_data_d = 1'b0;
            err_d      = !cmd_ok;
            phase_d    = 1'b0;
            bit_d      = 3'd0;
        end

        if (state_q == ST_SHIFT && half_done) begin
            cnt_d   = '0;
            phase_d = !phase_q;
            if (phase_q) begin
                // Falling SCK edge: sample miso_i, advance to the next bit.
                rx_d  = {rx_q[5:0], miso_i};
                tx_d  = {tx_q[6:0], 1'b0};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7 && cur_data_q && !wr_q) begin
                    rdat_d     = {rx_q, miso_i};
                    rdat_vld_d = 1'b1;
                end
            end
        end

        // Next byte is loaded on the last GAP cycle.
        if (gap_done) begin
            if (hdr_q != 2'd0) begin
                case (hdr_q)
                    2'd3:    tx_d = adr_q[23:16];
                    2'd2:    tx_d = adr_q[15:8];
                    default: tx_d = adr_q[7:0];
                endcase
                hdr_d      = hdr_q - 2'd1;
                cur_data_d = 1'b0;
            end else begin
                tx_d       = wr_q ? wdat_i : 8'h00;
                data_cnt_d = data_cnt_q - 9'd1;
                cur_data_d = 1'b1;
            end
        end
    end

    // NOTE: all datapath flops, rdat_q included, are reset so outputs are
    // defined immediately and a mid-transaction abort leaves nothing stale.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= 3'd0;
            tx_q       <= 8'h00;
            rx_q       <= 7'h00;
            adr_q      <= 24'h0;
            hdr_q      <= 2'd0;
            data_cnt_q <= 9'd0;
            has_data_q <= 1'b0;
            wr_q       <= 1'b0;
            cur_data_q <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= 8'h00;
            rdat_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            adr_q      <= adr_d;
            hdr_q      <= hdr_d;
            data_cnt_q <= data_cnt_d;
            has_data_q <= has_data_d;
            wr_q       <= wr_d;
            cur_data_q <= cur_data_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
            rdat_vld_q <= rdat_vld_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_master.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_master
//
// Directed bench for spi_flash_master with CLK_DIV=2, GAP=4, SS_HIGH=4.
// A vector table covers the single-byte, read, program and rejected commands;
// hand-written sequences cover a 256-byte program, a start while busy, and a
// reset in the middle of the address phase. A small SPI slave model drives
// miso_i from the table and collects mosi_o bytes on rising SCK edges.
// -----------------------------------------------------------------------------
module tb_spi_flash_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  cmd_i;
    logic [23:0] adr_i;
    logic [7:0]  len_i;
    logic [7:0]  wdat_i;
    logic        wdat_req_o;
    logic [7:0]  rdat_o;
    logic        rdat_vld_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        sck_o;
    logic        ss_o;
    logic        mosi_o;
    logic        miso_i;

    spi_flash_master #(
        .CLK_DIV (2),
        .GAP     (4),
        .SS_HIGH (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .cmd_i      (cmd_i),
        .adr_i      (adr_i),
        .len_i      (len_i),
        .wdat_i     (wdat_i),
        .wdat_req_o (wdat_req_o),
        .rdat_o     (rdat_o),
        .rdat_vld_o (rdat_vld_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .sck_o      (sck_o),
        .ss_o       (ss_o),
        .mosi_o     (mosi_o),
        .miso_i     (miso_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] adr;
        logic [7:0]  len;
        logic [7:0]  miso0;
        logic [7:0]  miso1;
        int          rises;
        int          reqs;
        int          vlds;
        int          errs;
        int          nbytes;
        logic [47:0] mosi;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
    } vec_t;

    vec_t vecs [6];

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of the current transaction.
    int         rises, done_cnt, err_cnt, vld_cnt, req_cnt, viol, done_lat;
    bit         ss_low, busy_first, sck_prev, mosi_prev;
    logic [7:0] mosi_b   [264];
    logic [7:0] rd_b     [256];
    logic [7:0] miso_src [256];

    task automatic check(input string name, input logic [47:0] actual, input logic [47:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One negedge observation; also plays the slave and the data source.
    task automatic sample(input int cyc, input bit extra);
        int b;
        wdat_i  = req_cnt[7:0];
        start_i = extra && (cyc == 10);
        if (extra && cyc == 10) cmd_i = 8'h04;
        if (sck_o && !sck_prev) begin
            rises++;
            b = (rises - 1) / 8;
            mosi_b[b] = {mosi_b[b][6:0], mosi_o};
            if (b >= 4) miso_i = miso_src[b - 4][7 - ((rises - 1) % 8)];
            else        miso_i = 1'b0;
        end
        if (ss_o && sck_o) viol++;
        if (sck_o && sck_prev && mosi_o !== mosi_prev) viol++;
        if (!ss_o) ss_low = 1'b1;
        if (cyc == 1) busy_first = busy_o;
        if (done_o) begin
            done_cnt++;
            if (done_lat == 0) done_lat = cyc;
        end
        if (err_o) err_cnt++;
        if (rdat_vld_o) begin
            if (vld_cnt < 256) rd_b[vld_cnt] = rdat_o;
            vld_cnt++;
        end
        if (wdat_req_o) req_cnt++;
        sck_prev  = sck_o;
        mosi_prev = mosi_o;
    endtask

    // Issue one request and observe until done_o, a stop rise count, or budget.
    task automatic run_txn(input logic [7:0] c, input logic [23:0] a, input logic [7:0] l,
                           input bit extra, input int stop_rise, input int budget);
        rises = 0; done_cnt = 0; err_cnt = 0; vld_cnt = 0; req_cnt = 0;
        viol = 0; done_lat = 0; ss_low = 1'b0; busy_first = 1'b0;
        sck_prev = 1'b0; mosi_prev = 1'b0; miso_i = 1'b0; wdat_i = 8'h00;
        for (int i = 0; i < 264; i++) mosi_b[i] = 8'h00;
        @(negedge clk_i);
        cmd_i = c; adr_i = a; len_i = l; start_i = 1'b1;
        @(negedge clk_i);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            sample(cyc, extra);
            if (done_cnt > 0 || (stop_rise != 0 && rises == stop_rise)) break;
            @(negedge clk_i);
        end
        start_i = 1'b0;
    endtask

    function automatic logic [47:0] mosi_head(input int n);
        logic [47:0] g = '0;
        for (int i = 0; i < n; i++) g = {g[39:0], mosi_b[i]};
        return g;
    endfunction

    initial begin
        int bad;
        rst_i = 1'b1; start_i = 1'b0; cmd_i = 8'h00; adr_i = 24'h0; len_i = 8'h00;
        wdat_i = 8'h00; miso_i = 1'b0;
        for (int i = 0; i < 256; i++) miso_src[i] = 8'h00;

        //           cmd    adr          len    miso0  miso1 rises reqs vlds errs nb  mosi                 rd0    rd1
        vecs[0] = '{8'h06, 24'h000000, 8'h00, 8'h00, 8'h00,   8,  0,   0,   0,  1, 48'h06,             8'h00, 8'h00};
        vecs[1] = '{8'h04, 24'h000000, 8'h00, 8'h00, 8'h00,   8,  0,   0,   0,  1, 48'h04,             8'h00, 8'h00};
        vecs[2] = '{8'h03, 24'h012345, 8'h01, 8'hA5, 8'h3C,  48,  0,   2,   0,  6, 48'h030123450000,   8'hA5, 8'h3C};
        vecs[3] = '{8'h9F, 24'h000000, 8'h00, 8'h00, 8'h00,   0,  0,   0,   1,  0, 48'h0,              8'h00, 8'h00};
        vecs[4] = '{8'h02, 24'hABCDEF, 8'h00, 8'h00, 8'h00,  40,  1,   0,   0,  5, 48'h02ABCDEF00,     8'h00, 8'h00};
        vecs[5] = '{8'h03, 24'hFFFFFF, 8'h00, 8'h81, 8'h00,  40,  0,   1,   0,  5, 48'h03FFFFFF00,     8'h81, 8'h00};

        // Reset state, sampled while reset is held and after release.
        repeat (2) @(negedge clk_i);
        check("rst ss_o",       ss_o,       1'b1);
        check("rst sck_o",      sck_o,      1'b0);
        check("rst mosi_o",     mosi_o,     1'b0);
        check("rst busy_o",     busy_o,     1'b0);
        check("rst done_o",     done_o,     1'b0);
        check("rst err_o",      err_o,      1'b0);
        check("rst wdat_req_o", wdat_req_o, 1'b0);
        check("rst rdat_vld_o", rdat_vld_o, 1'b0);
        check("rst rdat_o",     rdat_o,     8'h00);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle ss_o",      ss_o,       1'b1);

        // Table-driven vectors.
        foreach (vecs[v]) begin
            miso_src[0] = vecs[v].miso0;
            miso_src[1] = vecs[v].miso1;
            run_txn(vecs[v].cmd, vecs[v].adr, vecs[v].len, 1'b0, 0, 2000);
            check($sformatf("v%0d sck rises", v), rises,    vecs[v].rises);
            check($sformatf("v%0d done", v),      done_cnt, 1);
            check($sformatf("v%0d err", v),       err_cnt,  vecs[v].errs);
            check($sformatf("v%0d rdat_vld", v),  vld_cnt,  vecs[v].vlds);
            check($sformatf("v%0d wdat_req", v),  req_cnt,  vecs[v].reqs);
            check($sformatf("v%0d mosi", v),      mosi_head(vecs[v].nbytes), vecs[v].mosi);
            check($sformatf("v%0d spi timing", v), viol,    0);
            if (vecs[v].vlds >= 1) check($sformatf("v%0d rdat0", v), rd_b[0], vecs[v].rd0);
            if (vecs[v].vlds >= 2) check($sformatf("v%0d rdat1", v), rd_b[1], vecs[v].rd1);
            if (vecs[v].errs != 0) begin
                check($sformatf("v%0d done latency", v), done_lat, 1);
                check($sformatf("v%0d ss never low", v), ss_low,   1'b0);
            end else begin
                check($sformatf("v%0d busy after start", v), busy_first, 1'b1);
            end
        end

        // 256-byte program: len=255 must not wrap the byte counter.
        for (int i = 0; i < 256; i++) miso_src[i] = 8'h00;
        run_txn(8'h02, 24'h000010, 8'hFF, 1'b0, 0, 20000);
        check("prog256 done",     done_cnt, 1);
        check("prog256 rises",    rises,    2080);
        check("prog256 wdat_req", req_cnt,  256);
        check("prog256 header",   mosi_head(4), 48'h02000010);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mosi_b[4 + i] !== 8'(i)) bad++;
        check("prog256 data bytes", bad, 0);
        check("prog256 rdat_vld", vld_cnt, 0);
        check("prog256 timing",   viol,    0);

        // start_i while busy is ignored; the first transaction is unchanged.
        run_txn(8'h06, 24'h0, 8'h00, 1'b1, 0, 2000);
        check("busy start done",  done_cnt, 1);
        check("busy start rises", rises,    8);
        check("busy start mosi",  mosi_head(1), 48'h06);
        check("busy start err",   err_cnt,  0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (!ss_o || busy_o) bad++;
        end
        check("busy start no retrigger", bad, 0);

        // Reset during the adr[15:8] byte aborts without done_o.
        run_txn(8'h03, 24'h012345, 8'h01, 1'b0, 17, 2000);
        check("abort reached byte 2", rises, 17);
        rst_i = 1'b1;
        #1;
        check("abort ss_o",   ss_o,   1'b1);
        check("abort sck_o",  sck_o,  1'b0);
        check("abort busy_o", busy_o, 1'b0);
        bad = 0;
        repeat (2) begin
            @(negedge clk_i);
            if (done_o) bad++;
        end
        rst_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o || !ss_o) bad++;
        end
        check("abort no done", bad, 0);
        run_txn(8'h06, 24'h0, 8'h00, 1'b0, 0, 2000);
        check("post-abort done",  done_cnt, 1);
        check("post-abort rises", rises,    8);
        check("post-abort mosi",  mosi_head(1), 48'h06);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
